// File: rtl/apb_i2c_regif_pkg.sv
// Shared definitions for the APB-to-I2C register interface: address map,
// FSM state encoding and interrupt bit positions.
package apb_i2c_pkg;

  localparam int unsigned IRQ_W = 3;

  localparam logic [7:0] ADDR_TXDATA     = 8'h00;
  localparam logic [7:0] ADDR_RXDATA     = 8'h04;
  localparam logic [7:0] ADDR_CONFIG     = 8'h08;
  localparam logic [7:0] ADDR_TIMEOUT    = 8'h0C;
  localparam logic [7:0] ADDR_INT_STATUS = 8'h10;
  localparam logic [7:0] ADDR_INT_MASK   = 8'h14;

  localparam int unsigned INT_TX_EMPTY = 0;
  localparam int unsigned INT_RX_AVAIL = 1;
  localparam int unsigned INT_ERROR    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RDWAIT,
    ST_RESP
  } state_e;

  typedef enum logic [2:0] {
    REG_TXDATA,
    REG_RXDATA,
    REG_CONFIG,
    REG_TIMEOUT,
    REG_INT_STATUS,
    REG_INT_MASK,
    REG_NONE
  } reg_e;

endpackage

// File: rtl/apb_i2c_regif_if.sv
// APB3 bus bundle between the interconnect (master) and the register block (slave).
interface apb_i2c_regif_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_i2c_regif_irq.sv
// Sticky interrupt status with edge detection on FIFO flags, W1C clear,
// mask register and a registered IRQ output.
module apb_i2c_irq
  import apb_i2c_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tx_empty,
  input  logic             i_rx_empty,
  input  logic             i_error,
  input  logic             i_clr_we,
  input  logic [IRQ_W-1:0] i_clr,
  input  logic             i_mask_we,
  input  logic [IRQ_W-1:0] i_mask,
  output logic [IRQ_W-1:0] o_status,
  output logic [IRQ_W-1:0] o_mask,
  output logic             o_irq
);

  logic             r_tx_empty_d;
  logic             r_rx_empty_d;
  logic [IRQ_W-1:0] r_status;
  logic [IRQ_W-1:0] r_mask;
  logic             r_irq;
  logic [IRQ_W-1:0] w_set;
  logic [IRQ_W-1:0] w_clr;

  always_comb begin
    w_set               = '0;
    w_set[INT_TX_EMPTY] = i_tx_empty & ~r_tx_empty_d;
    w_set[INT_RX_AVAIL] = ~i_rx_empty & r_rx_empty_d;
    w_set[INT_ERROR]    = i_error;
    w_clr               = i_clr_we ? i_clr : '0;
  end

  // Edge history reloads from live inputs in reset so no edge fires on release.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_empty_d <= i_tx_empty;
      r_rx_empty_d <= i_rx_empty;
      r_status     <= '0;
      r_mask       <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_tx_empty_d <= i_tx_empty;
      r_rx_empty_d <= i_rx_empty;
      r_status     <= (r_status & ~w_clr) | w_set;
      if (i_mask_we) r_mask <= i_mask;
      r_irq        <= |(r_status & r_mask);
    end
  end

  assign o_status = r_status;
  assign o_mask   = r_mask;
  assign o_irq    = r_irq;

endmodule

// File: rtl/apb_i2c_regif.sv
// APB3 slave fronting the I2C core: TX/RX FIFO ports, CONFIG/TIMEOUT
// registers and interrupt block, with one wait state and RX read latency.
module apb_i2c_regif
  import apb_i2c_pkg::*;
#(
  parameter int unsigned      DATA_W  = 32,
  parameter int unsigned      ADDR_W  = 8,
  parameter int unsigned      CFG_W   = 14,
  parameter int unsigned      TMO_W   = 14,
  parameter logic [CFG_W-1:0] CFG_RST = '0,
  parameter logic [TMO_W-1:0] TMO_RST = '0,
  parameter int unsigned      RD_LAT  = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_i2c_regif_if.slave    apb,
  input  logic [DATA_W-1:0] READ_DATA_ON_RX,
  input  logic              TX_FULL,
  input  logic              TX_EMPTY,
  input  logic              RX_EMPTY,
  input  logic              ERROR,
  output logic [DATA_W-1:0] WRITE_DATA_ON_TX,
  output logic              WR_ENA,
  output logic              RD_ENA,
  output logic [CFG_W-1:0]  INTERNAL_I2C_REGISTER_CONFIG,
  output logic [TMO_W-1:0]  INTERNAL_I2C_REGISTER_TIMEOUT,
  output logic              IRQ
);

  state_e            r_state, w_next;
  logic              r_setup;
  reg_e              r_sel;
  logic              r_wr;
  logic              r_err;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_wdat;
  logic [DATA_W-1:0] r_prdata;
  logic              r_pready;
  logic              r_pslverr;
  logic [CFG_W-1:0]  r_cfg;
  logic [TMO_W-1:0]  r_tmo;

  reg_e              w_sel;
  logic              w_err;
  logic              w_accept;
  logic              w_pop;
  logic              w_commit;
  logic [DATA_W-1:0] w_rdata;
  logic [IRQ_W-1:0]  w_status;
  logic [IRQ_W-1:0]  w_mask;

  always_comb begin
    w_sel = REG_NONE;
    case (apb.PADDR)
      ADDR_W'(ADDR_TXDATA):     w_sel = REG_TXDATA;
      ADDR_W'(ADDR_RXDATA):     w_sel = REG_RXDATA;
      ADDR_W'(ADDR_CONFIG):     w_sel = REG_CONFIG;
      ADDR_W'(ADDR_TIMEOUT):    w_sel = REG_TIMEOUT;
      ADDR_W'(ADDR_INT_STATUS): w_sel = REG_INT_STATUS;
      ADDR_W'(ADDR_INT_MASK):   w_sel = REG_INT_MASK;
      default:                  w_sel = REG_NONE;
    endcase
  end

  always_comb begin
    w_err   = 1'b0;
    w_rdata = '0;
    unique case (w_sel)
      REG_NONE:       w_err = 1'b1;
      REG_TXDATA:     w_err = ~apb.PWRITE | TX_FULL;
      REG_RXDATA:     w_err = apb.PWRITE | RX_EMPTY;
      REG_CONFIG:     w_rdata = DATA_W'(r_cfg);
      REG_TIMEOUT:    w_rdata = DATA_W'(r_tmo);
      REG_INT_STATUS: w_rdata = DATA_W'(w_status);
      REG_INT_MASK:   w_rdata = DATA_W'(w_mask);
      default:        w_err = 1'b1;
    endcase
  end

  // A fresh SETUP phase must precede every accepted access, so PENABLE held
  // high across RESP->IDLE cannot start a second transfer.
  assign w_accept = (r_state == ST_IDLE) & apb.PSELx & apb.PENABLE & r_setup;
  assign w_pop    = w_accept & (w_sel == REG_RXDATA) & ~w_err;
  assign w_commit = (r_state == ST_RESP) & apb.PSELx & r_wr & ~r_err & ~PRESET;

  assign RD_ENA = w_pop & ~PRESET;
  assign WR_ENA = w_commit & (r_sel == REG_TXDATA);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_next = w_pop ? ST_RDWAIT : ST_RESP;
      ST_RDWAIT: begin
        if (!apb.PSELx)        w_next = ST_IDLE;
        else if (r_cnt == 2'd1) w_next = ST_RESP;
      end
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= ST_IDLE;
      r_setup   <= 1'b0;
      r_sel     <= REG_NONE;
      r_wr      <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_wdat    <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_cfg     <= CFG_RST;
      r_tmo     <= TMO_RST;
    end else begin
      r_state   <= w_next;
      r_setup   <= apb.PSELx & ~apb.PENABLE;
      r_pready  <= (w_next == ST_RESP);
      r_pslverr <= (r_state == ST_IDLE) & (w_next == ST_RESP) & w_err;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sel <= w_sel;
            r_wr  <= apb.PWRITE;
            r_err <= w_err;
            r_cnt <= 2'(RD_LAT);
            if (apb.PWRITE && !w_err) r_wdat <= apb.PWDATA;
            if (!apb.PWRITE && !w_pop) r_prdata <= w_err ? '0 : w_rdata;
          end
        end
        ST_RDWAIT: begin
          if (apb.PSELx) begin
            r_cnt <= r_cnt - 2'd1;
            if (r_cnt == 2'd1) r_prdata <= READ_DATA_ON_RX;
          end
        end
        ST_RESP: begin
          if (w_commit) begin
            case (r_sel)
              REG_CONFIG:  r_cfg <= r_wdat[CFG_W-1:0];
              REG_TIMEOUT: r_tmo <= r_wdat[TMO_W-1:0];
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  apb_i2c_irq u_irq (
    .i_clk      (PCLK),
    .i_rst      (PRESET),
    .i_tx_empty (TX_EMPTY),
    .i_rx_empty (RX_EMPTY),
    .i_error    (ERROR),
    .i_clr_we   (w_commit & (r_sel == REG_INT_STATUS)),
    .i_clr      (r_wdat[IRQ_W-1:0]),
    .i_mask_we  (w_commit & (r_sel == REG_INT_MASK)),
    .i_mask     (r_wdat[IRQ_W-1:0]),
    .o_status   (w_status),
    .o_mask     (w_mask),
    .o_irq      (IRQ)
  );

  assign apb.PRDATA                    = r_prdata;
  assign apb.PREADY                    = r_pready;
  assign apb.PSLVERR                   = r_pslverr;
  assign WRITE_DATA_ON_TX              = r_wdat;
  assign INTERNAL_I2C_REGISTER_CONFIG  = r_cfg;
  assign INTERNAL_I2C_REGISTER_TIMEOUT = r_tmo;

endmodule

// File: tb/tb_apb_i2c_regif.sv
// Directed and randomized bench for apb_i2c_regif against a register-level model.
module tb_apb_i2c_regif;

  localparam int unsigned RD_LAT  = 2;
  localparam logic [13:0] CFG_RST = 14'h0155;
  localparam logic [13:0] TMO_RST = 14'h00AA;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [31:0] READ_DATA_ON_RX;
  logic        TX_FULL, TX_EMPTY, RX_EMPTY, ERROR;
  logic [31:0] WRITE_DATA_ON_TX;
  logic        WR_ENA, RD_ENA, IRQ;
  logic [13:0] CFG_O, TMO_O;

  always #5 PCLK = ~PCLK;

  apb_i2c_regif_if #(.ADDR_W(8), .DATA_W(32)) apb ();

  apb_i2c_regif #(
    .DATA_W(32), .ADDR_W(8), .CFG_W(14), .TMO_W(14),
    .CFG_RST(CFG_RST), .TMO_RST(TMO_RST), .RD_LAT(RD_LAT)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(apb),
    .READ_DATA_ON_RX(READ_DATA_ON_RX), .TX_FULL(TX_FULL), .TX_EMPTY(TX_EMPTY),
    .RX_EMPTY(RX_EMPTY), .ERROR(ERROR), .WRITE_DATA_ON_TX(WRITE_DATA_ON_TX),
    .WR_ENA(WR_ENA), .RD_ENA(RD_ENA),
    .INTERNAL_I2C_REGISTER_CONFIG(CFG_O), .INTERNAL_I2C_REGISTER_TIMEOUT(TMO_O),
    .IRQ(IRQ)
  );

  int n_checks = 0;
  int n_err    = 0;

  // RX FIFO stand-in: returns rx_word exactly RD_LAT cycles after RD_ENA.
  logic [31:0] rx_word = '0;
  logic [1:0]  pv = '0;
  logic [31:0] pd0 = '0, pd1 = '0, last_wr = '0;
  int          n_rd_tot = 0, n_wr_tot = 0;

  always @(posedge PCLK) begin
    pv  <= {pv[0], RD_ENA};
    pd0 <= rx_word;
    pd1 <= pd0;
    if (RD_ENA) n_rd_tot <= n_rd_tot + 1;
    if (WR_ENA) begin
      n_wr_tot <= n_wr_tot + 1;
      last_wr  <= WRITE_DATA_ON_TX;
    end
  end
  assign READ_DATA_ON_RX = pv[1] ? pd1 : 32'hDEADBEEF;

  // Reference model state
  logic [13:0] m_cfg, m_tmo;
  logic [2:0]  m_status, m_mask;
  logic [31:0] m_prdata;

  logic [31:0] t_rdata;
  logic        t_serr, t_wr_rdy;
  int          t_cyc, t_nwr, t_nrd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic set_rx_empty(input logic v);
    if (RX_EMPTY === 1'b1 && v == 1'b0) m_status[1] = 1'b1;
    RX_EMPTY = v;
  endtask

  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      input logic err_in_resp);
    int w0, r0;
    bit done;
    w0 = n_wr_tot; r0 = n_rd_tot; t_cyc = 0; done = 0; t_wr_rdy = 0;
    @(posedge PCLK); #1;
    apb.PSELx = 1; apb.PENABLE = 0; apb.PWRITE = wr; apb.PADDR = addr; apb.PWDATA = wd;
    @(posedge PCLK); #1;
    apb.PENABLE = 1;
    while (!done && t_cyc < 16) begin
      @(negedge PCLK);
      t_cyc++;
      if (apb.PREADY) begin
        done = 1; t_rdata = apb.PRDATA; t_serr = apb.PSLVERR; t_wr_rdy = WR_ENA;
        if (err_in_resp) ERROR = 1;
      end
    end
    chk("pready_seen", 32'(done), 32'd1);
    @(posedge PCLK); #1;
    apb.PSELx = 0; apb.PENABLE = 0; ERROR = 0;
    @(posedge PCLK); #1;
    t_nwr = n_wr_tot - w0;
    t_nrd = n_rd_tot - r0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        wr, err, known;
    int          nrdy;

    PRESET = 1; apb.PSELx = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = '0; apb.PWDATA = '0;
    TX_FULL = 0; TX_EMPTY = 1; RX_EMPTY = 1; ERROR = 0;
    m_cfg = CFG_RST; m_tmo = TMO_RST; m_status = '0; m_mask = '0; m_prdata = '0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_pready", 32'(apb.PREADY), 0);
    chk("rst_pslverr", 32'(apb.PSLVERR), 0);
    chk("rst_prdata", apb.PRDATA, 0);
    chk("rst_wr_ena", 32'(WR_ENA), 0);
    chk("rst_rd_ena", 32'(RD_ENA), 0);
    chk("rst_txdata", WRITE_DATA_ON_TX, 0);
    chk("rst_config", 32'(CFG_O), 32'h155);
    chk("rst_timeout", 32'(TMO_O), 32'h0AA);
    chk("rst_irq", 32'(IRQ), 0);
    @(posedge PCLK); #1 PRESET = 0;

    xfer(0, 8'h08, '0, 0);
    chk("cfg_rd_data", t_rdata, 32'h155);
    chk("cfg_rd_cycles", t_cyc, 2);
    chk("cfg_rd_err", 32'(t_serr), 0);
    m_prdata = 32'h155;

    xfer(1, 8'h00, 32'h0000ABCD, 0);
    chk("tx_wr_pulses", t_nwr, 1);
    chk("tx_wr_in_resp", 32'(t_wr_rdy), 1);
    chk("tx_wr_data", last_wr, 32'h0000ABCD);
    chk("tx_wr_err", 32'(t_serr), 0);
    TX_FULL = 1;
    xfer(1, 8'h00, 32'h00001111, 0);
    chk("tx_full_pulses", t_nwr, 0);
    chk("tx_full_err", 32'(t_serr), 1);
    TX_FULL = 0;

    rx_word = 32'h12345678;
    set_rx_empty(0);
    xfer(0, 8'h04, '0, 0);
    chk("rx_rd_data", t_rdata, 32'h12345678);
    chk("rx_rd_cycles", t_cyc, 2 + RD_LAT);
    chk("rx_rd_pops", t_nrd, 1);
    chk("rx_rd_err", 32'(t_serr), 0);
    set_rx_empty(1);
    xfer(0, 8'h04, '0, 0);
    chk("rx_empty_err", 32'(t_serr), 1);
    chk("rx_empty_data", t_rdata, 0);
    chk("rx_empty_pops", t_nrd, 0);
    chk("rx_empty_cycles", t_cyc, 2);
    m_prdata = '0;

    xfer(1, 8'h18, 32'hFFFFFFFF, 0);
    chk("unmapped_err", 32'(t_serr), 1);
    xfer(1, 8'h09, 32'hFFFFFFFF, 0);
    chk("misalign_err", 32'(t_serr), 1);
    chk("unmapped_cfg", 32'(CFG_O), 32'(m_cfg));
    chk("unmapped_tmo", 32'(TMO_O), 32'(m_tmo));

    xfer(1, 8'h10, 32'h7, 0); m_status = '0;
    xfer(1, 8'h14, 32'h4, 0); m_mask = 3'h4;
    chk("irq_idle", 32'(IRQ), 0);
    ERROR = 1; @(posedge PCLK); #1 ERROR = 0;
    @(posedge PCLK); #1;
    chk("irq_after_error", 32'(IRQ), 1);
    xfer(0, 8'h10, '0, 0);
    chk("status_error", t_rdata, 32'h4);
    xfer(1, 8'h10, 32'h4, 0);
    chk("irq_after_w1c", 32'(IRQ), 0);
    xfer(0, 8'h10, '0, 0);
    chk("status_cleared", t_rdata, 0);
    xfer(1, 8'h10, 32'h4, 1);
    chk("irq_set_wins", 32'(IRQ), 1);
    xfer(0, 8'h10, '0, 0);
    chk("status_set_wins", t_rdata, 32'h4);
    xfer(1, 8'h10, 32'h7, 0); m_status = '0;
    m_prdata = 32'h4;

    // PENABLE held high after the response must not start another transfer.
    nrdy = 0;
    begin
      int w0;
      w0 = n_wr_tot;
      @(posedge PCLK); #1;
      apb.PSELx = 1; apb.PENABLE = 0; apb.PWRITE = 1; apb.PADDR = 8'h00; apb.PWDATA = 32'h55;
      @(posedge PCLK); #1 apb.PENABLE = 1;
      for (int i = 0; i < 6; i++) begin
        @(negedge PCLK);
        if (apb.PREADY) nrdy++;
      end
      @(posedge PCLK); #1 apb.PSELx = 0; apb.PENABLE = 0;
      @(posedge PCLK); #1;
      chk("hold_pready_count", nrdy, 1);
      chk("hold_wr_pulses", n_wr_tot - w0, 1);
      chk("hold_wr_data", last_wr, 32'h55);
    end

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 8))
        0: addr = 8'h00;  1: addr = 8'h04;  2: addr = 8'h08;
        3: addr = 8'h0C;  4: addr = 8'h10;  5: addr = 8'h14;
        6: addr = 8'h18;  7: addr = 8'h1C;
        default: addr = 8'($urandom_range(0, 255));
      endcase
      wr = 1'($urandom_range(0, 1));
      wd = $urandom();
      if (addr == 8'h00) TX_FULL = 1'($urandom_range(0, 1));
      if (addr == 8'h04 && !wr) begin
        set_rx_empty(1'($urandom_range(0, 1)));
        rx_word = $urandom();
      end
      xfer(wr, addr, wd, 0);
      known = (addr == 8'h00) || (addr == 8'h04) || (addr == 8'h08) ||
              (addr == 8'h0C) || (addr == 8'h10) || (addr == 8'h14);
      if (!known)              err = 1;
      else if (addr == 8'h00)  err = !wr || TX_FULL;
      else if (addr == 8'h04)  err = wr || RX_EMPTY;
      else                     err = 0;
      if (!wr) begin
        if (err)                  m_prdata = '0;
        else if (addr == 8'h04)   m_prdata = rx_word;
        else if (addr == 8'h08)   m_prdata = 32'(m_cfg);
        else if (addr == 8'h0C)   m_prdata = 32'(m_tmo);
        else if (addr == 8'h10)   m_prdata = 32'(m_status);
        else                      m_prdata = 32'(m_mask);
      end
      chk("rnd_prdata", t_rdata, m_prdata);
      chk("rnd_pslverr", 32'(t_serr), 32'(err));
      chk("rnd_cycles", t_cyc, (addr == 8'h04 && !wr && !err) ? 2 + RD_LAT : 2);
      chk("rnd_wr_pulses", t_nwr, (addr == 8'h00 && wr && !err) ? 1 : 0);
      chk("rnd_rd_pulses", t_nrd, (addr == 8'h04 && !wr && !err) ? 1 : 0);
      if (addr == 8'h00 && wr && !err) chk("rnd_tx_data", last_wr, wd);
      if (wr && !err) begin
        if (addr == 8'h08) m_cfg = wd[13:0];
        if (addr == 8'h0C) m_tmo = wd[13:0];
        if (addr == 8'h10) m_status = m_status & ~wd[2:0];
        if (addr == 8'h14) m_mask = wd[2:0];
      end
      chk("rnd_config", 32'(CFG_O), 32'(m_cfg));
      chk("rnd_timeout", 32'(TMO_O), 32'(m_tmo));
      chk("rnd_irq", 32'(IRQ), 32'(|(m_status & m_mask)));
    end
    TX_FULL = 0;

    xfer(1, 8'h08, 32'h00002A5A, 0); m_cfg = 14'h2A5A;
    chk("pre_rst_cfg", 32'(CFG_O), 32'h2A5A);
    rx_word = 32'hCAFEF00D;
    set_rx_empty(0);
    @(posedge PCLK); #1;
    apb.PSELx = 1; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 8'h04;
    @(posedge PCLK); #1 apb.PENABLE = 1;
    @(negedge PCLK);
    chk("rdwait_rd_ena", 32'(RD_ENA), 1);
    @(posedge PCLK); #1 PRESET = 1;
    @(posedge PCLK); #1 PRESET = 0; apb.PSELx = 0; apb.PENABLE = 0;
    m_cfg = CFG_RST; m_tmo = TMO_RST; m_status = '0; m_mask = '0; m_prdata = '0;
    @(negedge PCLK);
    chk("mid_rst_pready", 32'(apb.PREADY), 0);
    chk("mid_rst_pslverr", 32'(apb.PSLVERR), 0);
    chk("mid_rst_prdata", apb.PRDATA, 0);
    chk("mid_rst_config", 32'(CFG_O), 32'(CFG_RST));
    chk("mid_rst_irq", 32'(IRQ), 0);
    xfer(1, 8'h0C, 32'h00003FFF, 0);
    chk("post_rst_tmo_err", 32'(t_serr), 0);
    chk("post_rst_timeout", 32'(TMO_O), 32'h3FFF);
    xfer(0, 8'h0C, '0, 0);
    chk("post_rst_tmo_rd", t_rdata, 32'h3FFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_i2c_regif.md
Name: apb_i2c_regif

Overview:
- Parametrised APB3 slave that fronts the I2C core: TX/RX FIFO data ports, CONFIG/TIMEOUT registers, and a maskable sticky interrupt block.
- Adds wait-state handling and configurable RX FIFO read latency.
- Drives PSLVERR for decode and FIFO faults; the raw core ERROR is no longer passed straight to PSLVERR.
- Sits between the APB interconnect and the I2C core/FIFOs.

Parameters:
- DATA_W, 32, APB data width (PWDATA/PRDATA/FIFO data).
- ADDR_W, 8, decoded PADDR width (upper bits ignored).
- CFG_W, 14, CONFIG register width.
- TMO_W, 14, TIMEOUT register width.
- CFG_RST, 0, CONFIG reset value.
- TMO_RST, 0, TIMEOUT reset value.
- RD_LAT, 1, RX FIFO read latency in cycles (legal 1..3).

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous, active-high reset.
- PSELx  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  registered read data.
- PREADY  out  1  transfer complete (registered).
- PSLVERR  out  1  transfer error, valid only with PREADY.
- READ_DATA_ON_RX  in  DATA_W  RX FIFO data, valid RD_LAT cycles after RD_ENA.
- TX_FULL  in  1  TX FIFO full.
- TX_EMPTY  in  1  TX FIFO empty.
- RX_EMPTY  in  1  RX FIFO empty.
- ERROR  in  1  I2C core error.
- WRITE_DATA_ON_TX  out  DATA_W  TX push data.
- WR_ENA  out  1  TX push strobe, 1 cycle.
- RD_ENA  out  1  RX pop strobe, 1 cycle.
- INTERNAL_I2C_REGISTER_CONFIG  out  CFG_W  config to core.
- INTERNAL_I2C_REGISTER_TIMEOUT  out  TMO_W  timeout to core.
- IRQ  out  1  OR of (INT_STATUS & INT_MASK).

Behaviour:
- Map (PADDR[1:0] must be 0):
  - 0x00 TXDATA: W.
  - 0x04 RXDATA: R.
  - 0x08 CONFIG: RW, CFG_W bits, upper bits read 0.
  - 0x0C TIMEOUT: RW, TMO_W bits.
  - 0x10 INT_STATUS: R/W1C, 3 bits.
  - 0x14 INT_MASK: RW, 3 bits.
- Reset: FSM=IDLE; PRDATA=0; PREADY=0; PSLVERR=0; WR_ENA=0; RD_ENA=0; WRITE_DATA_ON_TX=0; CONFIG=CFG_RST; TIMEOUT=TMO_RST; INT_STATUS=0; INT_MASK=0; IRQ=0; edge-detect flops are loaded from the current inputs, so no spurious edge fires.
- FSM states: IDLE, RDWAIT, RESP.
- IDLE:
  - Acts when PSELx & PENABLE. Decodes the access and latches err and rd/wr intent.
  - Valid RXDATA read with RX_EMPTY=0: RD_ENA=1 this cycle (combinational from state/decode); load count=RD_LAT; go RDWAIT.
  - Any other access: capture register read data into PRDATA if read; go RESP.
- RDWAIT: decrement count; on count==1, capture READ_DATA_ON_RX into PRDATA and go RESP.
- RESP:
  - PREADY=1 and PSLVERR=err for exactly 1 cycle, then IDLE.
  - Write side effects are committed on the RESP clock edge, only if err=0:
    - TXDATA: WR_ENA=1 for this cycle; WRITE_DATA_ON_TX = latched PWDATA.
    - CONFIG, TIMEOUT, INT_MASK: register loads.
    - INT_STATUS: W1C.
- Latency:
  - Register access: PREADY in 2nd PENABLE cycle (1 wait state).
  - RXDATA read: PREADY in cycle 2+RD_LAT.
- err=1 (no side effects) for any of:
  - unmapped address or PADDR[1:0]≠0;
  - write to RXDATA;
  - read of TXDATA (PRDATA=0);
  - TXDATA write with TX_FULL=1 (sampled in IDLE);
  - RXDATA read with RX_EMPTY=1 (no RD_ENA; PRDATA=0).
- Errored reads drive PRDATA=0. PRDATA holds its value between transfers.
- INT_STATUS bits:
  - bit0: set on TX_EMPTY 0→1.
  - bit1: set on RX_EMPTY 1→0.
  - bit2: set each cycle ERROR=1.
  - A set in the same cycle as a W1C clear wins.
- IRQ is registered: asserted the cycle after status&mask becomes nonzero.
- PSELx deasserted in RDWAIT/RESP (protocol abort): return to IDLE next cycle.
  - No WR_ENA and no register write.
  - An already-issued RD_ENA is not retracted; its data is discarded.
- PRESET asserted mid-transfer: immediate reset state on the next edge; no strobes.
- Back-to-back transfers: a new access is accepted only in IDLE; PENABLE held high across RESP→IDLE does not re-trigger, because a new SETUP phase (PENABLE=0) is required first.

Decomposition:
- Package apb_i2c_pkg holds:
  - address offset localparams: TXDATA, RXDATA, CONFIG, TIMEOUT, INT_STATUS, INT_MASK;
  - FSM state enum;
  - INT_STATUS bit indices;
  - IRQ_W=3.
- One sub-module, apb_i2c_irq: edge detectors, sticky status, W1C, mask, registered IRQ.

Test Plan:
- Reset, then read CONFIG at 0x08 with CFG_RST=14'h0155 → PRDATA=0x155, PREADY in 2nd access cycle, PSLVERR=0.
- Write 0x0000ABCD to TXDATA with TX_FULL=0 → one WR_ENA pulse in the RESP cycle, WRITE_DATA_ON_TX=0xABCD. Repeat with TX_FULL=1 → no WR_ENA, PSLVERR=1.
- RD_LAT=2, RX_EMPTY=0, READ_DATA_ON_RX=0x12345678 two cycles after RD_ENA → PRDATA=0x12345678, PREADY in 4th access cycle. Repeat with RX_EMPTY=1 → no RD_ENA, PSLVERR=1, PRDATA=0.
- Accesses to 0x18 and 0x09 → PSLVERR=1, CONFIG/TIMEOUT unchanged.
- INT_MASK=0x4, pulse ERROR one cycle → INT_STATUS=0x4, IRQ=1. W1C 0x4 → IRQ=0. Repeat with ERROR=1 during the W1C RESP cycle → bit stays set.
- PRESET asserted during RDWAIT → next cycle IDLE, PREADY=0, CONFIG=CFG_RST. A subsequent write to 0x0C of 0x3FFF → TIMEOUT=0x3FFF.
